// File: rtl/tpu_dma_pkg.sv
// Shared types and constants for the TPU inter-layer DMA controller:
// FSM state encoding, request mode codes and per-stage transfer lengths.
package tpu_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dma_state_t;

    localparam logic [1:0] MODE_NONE = 2'd0;
    localparam logic [1:0] MODE_CONV = 2'd1;
    localparam logic [1:0] MODE_FC   = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    localparam int unsigned LEN_W = 16;

    localparam logic [LEN_W-1:0] LEN_CONV0 = 16'd1176;  // 14x14x6
    localparam logic [LEN_W-1:0] LEN_CONV1 = 16'd400;   // 5x5x16
    localparam logic [LEN_W-1:0] LEN_FC0   = 16'd120;
    localparam logic [LEN_W-1:0] LEN_FC1   = 16'd84;

    // Unlisted mode/stage pairs decode to zero words (completion-only request).
    function automatic logic [LEN_W-1:0] dma_len(input logic [1:0] mode,
                                                 input logic [1:0] nth);
        logic [LEN_W-1:0] len;
        len = '0;
        case (mode)
            MODE_CONV: begin
                if (nth == 2'd0)      len = LEN_CONV0;
                else if (nth == 2'd1) len = LEN_CONV1;
            end
            MODE_FC: begin
                if (nth == 2'd0)      len = LEN_FC0;
                else if (nth == 2'd1) len = LEN_FC1;
            end
            default: len = '0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/tpu_dma_ctrl_if.sv
// Bundle of the layer-controller handshake and the source/destination BRAM
// ports seen by the DMA controller.
interface tpu_dma_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 11
);
    logic [1:0]        start_dma_i;
    logic [1:0]        nth_conv_i;
    logic              dma_done_o;
    logic              busy_o;
    logic              src_rd_en_o;
    logic [ADDR_W-1:0] src_addr_o;
    logic [DATA_W-1:0] src_rdata_i;
    logic              dst_wr_en_o;
    logic [ADDR_W-1:0] dst_addr_o;
    logic [DATA_W-1:0] dst_wdata_o;

    modport master (
        output start_dma_i, nth_conv_i, src_rdata_i,
        input  dma_done_o, busy_o, src_rd_en_o, src_addr_o,
               dst_wr_en_o, dst_addr_o, dst_wdata_o
    );

    modport slave (
        input  start_dma_i, nth_conv_i, src_rdata_i,
        output dma_done_o, busy_o, src_rd_en_o, src_addr_o,
               dst_wr_en_o, dst_addr_o, dst_wdata_o
    );

endinterface

// File: rtl/tpu_dma_ctrl.sv
// Copies one layer's output BRAM into the next layer's input BRAM: linear
// reads 0..N-1, each written one cycle later once the BRAM data returns.
module tpu_dma_ctrl
    import tpu_dma_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 11
) (
    input  logic           clk,
    input  logic           rst_n,
    tpu_dma_ctrl_if.slave  bus
);

    dma_state_t        state_q;
    dma_state_t        state_d;
    logic [1:0]        start_q;
    logic [1:0]        mode_q;
    logic [1:0]        nth_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;

    logic              accept;
    logic [LEN_W-1:0]  req_len;
    logic [LEN_W-1:0]  cur_len;
    logic [ADDR_W-1:0] last_addr;
    logic              rd_last;
    logic              rd_en;
    logic [DATA_W-1:0] wdata;

    // Only a 0 -> nonzero transition seen in IDLE starts a transfer.
    assign accept    = (state_q == ST_IDLE) && (bus.start_dma_i != 2'd0)
                       && (start_q == 2'd0);
    assign req_len   = dma_len(bus.start_dma_i, bus.nth_conv_i);
    assign cur_len   = dma_len(mode_q, nth_q);
    assign last_addr = ADDR_W'(cur_len - LEN_W'(1));
    assign rd_last   = (rd_addr_q == last_addr);
    assign rd_en     = (state_q == ST_XFER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (req_len == '0) ? ST_DONE : ST_XFER;
                end
            end
            ST_XFER: begin
                if (rd_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q   <= '0;
            mode_q    <= '0;
            nth_q     <= '0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            start_q <= bus.start_dma_i;
            if (accept) begin
                mode_q    <= bus.start_dma_i;
                nth_q     <= bus.nth_conv_i;
                rd_addr_q <= '0;
            end else if (rd_en && !rd_last) begin
                rd_addr_q <= rd_addr_q + ADDR_W'(1);
            end
            // Write stage trails the read by the BRAM's one-cycle read latency.
            wr_en_q   <= rd_en;
            wr_addr_q <= rd_addr_q;
        end
    end

    always_comb begin
        wdata           = wr_en_q ? bus.src_rdata_i : '0;
        bus.busy_o      = (state_q != ST_IDLE);
        bus.dma_done_o  = (state_q == ST_DONE);
        bus.src_rd_en_o = rd_en;
        bus.src_addr_o  = rd_en ? rd_addr_q : '0;
        bus.dst_wr_en_o = wr_en_q;
        bus.dst_addr_o  = wr_en_q ? wr_addr_q : '0;
        bus.dst_wdata_o = wdata;
    end

endmodule

// File: tb/tb_tpu_dma_ctrl.sv
// Directed bench for tpu_dma_ctrl: stage lengths, zero-length requests,
// ignored edges, mid-transfer reset and back-to-back requests.
module tb_tpu_dma_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 11;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    tpu_dma_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    tpu_dma_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return 32'h5A00_0000 ^ {a, 5'b10101, a, 5'b01010};
    endfunction

    // Source BRAM model: registered read, one cycle latency.
    logic [DW-1:0] rdata_q;
    always @(posedge clk) begin
        if (bus.src_rd_en_o) rdata_q <= pat(bus.src_addr_o);
    end
    assign bus.src_rdata_i = rdata_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; that cycle is the acceptance cycle k.
    // Cycle k+c is sampled at iteration c; stops after the first done pulse.
    task automatic run(input logic [1:0] mode, input logic [1:0] nth,
                       input int hold, input int glitch_at, input int max_c,
                       output int rd, output int wr, output int err,
                       output int done_c, output int busy_c);
        rd = 0; wr = 0; err = 0; done_c = 0; busy_c = 0;
        bus.start_dma_i = mode;
        bus.nth_conv_i  = nth;
        for (int c = 1; c <= max_c; c++) begin
            @(negedge clk);
            if (bus.busy_o) busy_c++;
            if (bus.src_rd_en_o) begin
                if (bus.src_addr_o !== AW'(rd)) err++;
                rd++;
            end
            if (bus.dst_wr_en_o) begin
                if (bus.dst_addr_o !== AW'(wr) || bus.dst_wdata_o !== pat(AW'(wr))) err++;
                wr++;
            end
            if (c == hold) begin
                bus.start_dma_i = 2'd0;
                bus.nth_conv_i  = 2'd3 - nth;
            end
            if (glitch_at > 0) begin
                if (c == glitch_at)     bus.start_dma_i = 2'd0;
                if (c == glitch_at + 1) bus.start_dma_i = mode;
                if (c == glitch_at + 3) bus.start_dma_i = 2'd0;
            end
            if (bus.dma_done_o) begin
                done_c = c;
                break;
            end
        end
    endtask

    int rd, wr, err, done_c, busy_c;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.start_dma_i = 2'd0;
        bus.nth_conv_i  = 2'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.dma_done_o, 0);
        chk("rst_rd_en", bus.src_rd_en_o, 0);
        chk("rst_wr_en", bus.dst_wr_en_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", bus.busy_o, 0);

        // conv stage 0, start held 3 cycles
        run(2'd1, 2'd0, 3, 0, 1300, rd, wr, err, done_c, busy_c);
        chk("c0_reads", rd, 1176);
        chk("c0_writes", wr, 1176);
        chk("c0_seq_err", err, 0);
        chk("c0_done_cyc", done_c, 1178);
        chk("c0_busy_cyc", busy_c, 1178);
        @(negedge clk);
        chk("c0_done_single", bus.dma_done_o, 0);
        chk("c0_idle_gap", bus.busy_o, 0);

        // back-to-back fc stage 1 then fc stage 0
        run(2'd2, 2'd1, 1, 0, 200, rd, wr, err, done_c, busy_c);
        chk("f1_reads", rd, 84);
        chk("f1_writes", wr, 84);
        chk("f1_seq_err", err, 0);
        chk("f1_done_cyc", done_c, 86);
        chk("f1_busy_cyc", busy_c, 86);
        @(negedge clk);
        chk("f1_idle_gap", bus.busy_o, 0);
        run(2'd2, 2'd0, 1, 0, 200, rd, wr, err, done_c, busy_c);
        chk("f0_reads", rd, 120);
        chk("f0_writes", wr, 120);
        chk("f0_seq_err", err, 0);
        chk("f0_done_cyc", done_c, 122);
        chk("f0_busy_cyc", busy_c, 122);

        // edge coinciding with DONE must not start a transfer
        bus.start_dma_i = 2'd1;
        bus.nth_conv_i  = 2'd1;
        @(negedge clk);
        chk("done_edge_idle1", bus.busy_o, 0);
        @(negedge clk);
        chk("done_edge_idle2", bus.busy_o, 0);
        chk("done_edge_no_rd", bus.src_rd_en_o, 0);
        bus.start_dma_i = 2'd0;
        @(negedge clk);

        // zero-length requests
        run(2'd3, 2'd0, 1, 0, 10, rd, wr, err, done_c, busy_c);
        chk("rsv_reads", rd, 0);
        chk("rsv_writes", wr, 0);
        chk("rsv_done_cyc", done_c, 1);
        chk("rsv_busy_cyc", busy_c, 1);
        @(negedge clk);
        chk("rsv_idle", bus.busy_o, 0);
        run(2'd1, 2'd2, 1, 0, 10, rd, wr, err, done_c, busy_c);
        chk("n2_reads", rd, 0);
        chk("n2_writes", wr, 0);
        chk("n2_done_cyc", done_c, 1);
        @(negedge clk);
        chk("n2_idle", bus.busy_o, 0);

        // second edge mid-transfer is ignored
        run(2'd1, 2'd1, 1, 200, 600, rd, wr, err, done_c, busy_c);
        chk("c1_reads", rd, 400);
        chk("c1_writes", wr, 400);
        chk("c1_seq_err", err, 0);
        chk("c1_done_cyc", done_c, 402);
        @(negedge clk);
        chk("c1_done_single", bus.dma_done_o, 0);
        chk("c1_idle", bus.busy_o, 0);
        @(negedge clk);
        chk("c1_not_queued", bus.busy_o, 0);

        // reset at read word 50, start held through release
        run(2'd1, 2'd0, 100000, 0, 51, rd, wr, err, done_c, busy_c);
        chk("ab_reads", rd, 51);
        chk("ab_writes", wr, 50);
        chk("ab_seq_err", err, 0);
        chk("ab_no_done", done_c, 0);
        rst_n = 1'b0;
        #1;
        chk("ab_busy0", bus.busy_o, 0);
        chk("ab_rd_en0", bus.src_rd_en_o, 0);
        chk("ab_wr_en0", bus.dst_wr_en_o, 0);
        chk("ab_done0", bus.dma_done_o, 0);
        chk("ab_src_addr0", 32'(bus.src_addr_o), 0);
        chk("ab_dst_addr0", 32'(bus.dst_addr_o), 0);
        chk("ab_wdata0", bus.dst_wdata_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(2'd1, 2'd0, 3, 0, 1300, rd, wr, err, done_c, busy_c);
        chk("rs_reads", rd, 1176);
        chk("rs_writes", wr, 1176);
        chk("rs_seq_err", err, 0);
        chk("rs_done_cyc", done_c, 1178);
        @(negedge clk);
        chk("rs_idle", bus.busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
